img_downscale_28: RTL and testbench



---
 rtl/img_downscale_28_pkg.sv | 15 +
 rtl/img_downscale_28_if.sv | 16 +
 rtl/img_downscale_28_col_accum_bank.sv | 43 ++++
 rtl/img_downscale_28.sv | 184 ++++++++++++++++++
 tb/tb_img_downscale_28.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/img_downscale_28_pkg.sv
// img_proc_pkg: constants and types shared by the down-sampler and the
// downstream capture FSM that consumes its 28x28 output stream.
package img_proc_pkg;

  localparam int IMG_DIM     = 28;
  localparam int IMG_PIX_CNT = IMG_DIM * IMG_DIM;
  localparam int PIX_W       = 12;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACCUM      = 2'd1,
    DONE       = 2'd2
  } ds_state_t;

endpackage

// File: rtl/img_downscale_28_if.sv
// img_downscale_28_if: FVAL/DVAL/DATA pixel stream as produced by the CCD
// front end and consumed by the capture FSM.
interface img_downscale_28_if
  import img_proc_pkg::*;
#(
  parameter int DW = PIX_W
) ();

  logic          FVAL;
  logic          DVAL;
  logic [DW-1:0] DATA;

  modport master (output FVAL, output DVAL, output DATA);
  modport slave  (input  FVAL, input  DVAL, input  DATA);

endinterface

// File: rtl/img_downscale_28_col_accum_bank.sv
// col_accum_bank: one running-sum register per output column. A block
// accumulates across BLK lines in its column register; sumOut is the
// addressed register plus the incoming pixel, used both for the add path
// and for the final block sum.
module col_accum_bank
  import img_proc_pkg::*;
#(
  parameter int DEPTH = IMG_DIM,
  parameter int IDX_W = 5,
  parameter int DW    = PIX_W,
  parameter int SUM_W = 20
) (
  input  logic             pxlclk,
  input  logic             rst_n,
  input  logic             wrEn,
  input  logic             load,
  input  logic [IDX_W-1:0] idx,
  input  logic [DW-1:0]    addVal,
  output logic [SUM_W-1:0] sumOut
);

  logic [DEPTH-1:0][SUM_W-1:0] accVec;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_col
      logic [SUM_W-1:0] accReg;

      // Column register: restart on the block's first pixel, otherwise add.
      always_ff @(posedge pxlclk or negedge rst_n) begin
        if (!rst_n) begin
          accReg <= '0;
        end else if (wrEn && (idx == IDX_W'(gi))) begin
          accReg <= load ? SUM_W'(addVal) : sumOut;
        end
      end

      assign accVec[gi] = accReg;
    end
  endgenerate

  assign sumOut = accVec[idx] + SUM_W'(addVal);

endmodule

// File: rtl/img_downscale_28.sv
// img_downscale_28: crops a centred OUT_DIM*BLK square from each frame and
// box-averages every BLK x BLK block into one output pixel, emitted in
// raster order with a one-cycle strobe.
// Build option: define IMG_INVERT_EN to output (2^PIX_W-1) - average.
module img_downscale_28 #(
  parameter int IN_W    = 640,
  parameter int IN_H    = 480,
  parameter int BLK     = 16,
  parameter int OUT_DIM = 28,
  parameter int PIX_W   = img_proc_pkg::PIX_W
) (
  input  logic               pxlclk,
  input  logic               rst_n,
  img_downscale_28_if.slave  inBus,
  img_downscale_28_if.master outBus,
  output logic               oFrame_err
);
  import img_proc_pkg::*;

  localparam int LOG2BLK = $clog2(BLK);
  localparam int SHIFT   = 2 * LOG2BLK;
  localparam int SUM_W   = PIX_W + SHIFT;
  localparam int SPAN    = BLK * OUT_DIM;
  localparam int X_OFF   = (IN_W - SPAN) / 2;
  localparam int Y_OFF   = (IN_H - SPAN) / 2;
  localparam int XW      = $clog2(IN_W);
  localparam int YW      = $clog2(IN_H);
  localparam int BC_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int NOUT    = OUT_DIM * OUT_DIM;
  localparam int OCW     = $clog2(NOUT + 1);

  localparam logic [XW-1:0]      X_OFF_V    = XW'(X_OFF);
  localparam logic [YW-1:0]      Y_OFF_V    = YW'(Y_OFF);
  localparam logic [XW-1:0]      SPAN_X_V   = XW'(SPAN);
  localparam logic [YW-1:0]      SPAN_Y_V   = YW'(SPAN);
  localparam logic [XW-1:0]      X_LAST_V   = XW'(IN_W - 1);
  localparam logic [YW-1:0]      Y_LAST_V   = YW'(IN_H - 1);
  localparam logic [OCW-1:0]     OUT_LAST_V = OCW'(NOUT - 1);
  localparam logic [LOG2BLK-1:0] SUB_LAST   = {LOG2BLK{1'b1}};
  localparam logic [PIX_W-1:0]   PIX_MAX    = {PIX_W{1'b1}};

  ds_state_t          state, stateNext;
  logic               fvalBuf, armed, rising, pixVld;
  logic [XW-1:0]      xCnt, xCntNext, relX;
  logic [YW-1:0]      yCnt, yCntNext, relY;
  logic [OCW-1:0]     outCnt, outCntNext;
  logic               inWin, winPix, accLoad, lastPix, errNext;
  logic [LOG2BLK-1:0] sx, sy;
  logic [BC_W-1:0]    bc;
  logic [SUM_W-1:0]   sumOut;
  logic [PIX_W-1:0]   avg, pixOut;
  logic               dvalReg;
  logic [15:0]        dataReg;

  // A frame start needs FVAL to have been seen low since reset, so a frame
  // already running when reset is released is skipped.
  assign rising = inBus.FVAL & ~fvalBuf & armed;
  assign pixVld = inBus.FVAL & inBus.DVAL &
                  ((state == ACCUM) | ((state == WAIT_FRAME) & rising));

  assign relX    = xCnt - X_OFF_V;
  assign relY    = yCnt - Y_OFF_V;
  assign inWin   = (xCnt >= X_OFF_V) && (relX < SPAN_X_V) &&
                   (yCnt >= Y_OFF_V) && (relY < SPAN_Y_V);
  assign sx      = relX[LOG2BLK-1:0];
  assign sy      = relY[LOG2BLK-1:0];
  assign bc      = BC_W'(relX >> LOG2BLK);
  assign winPix  = pixVld & inWin;
  assign accLoad = (sx == '0) && (sy == '0);
  assign lastPix = winPix && (sx == SUB_LAST) && (sy == SUB_LAST);

  col_accum_bank #(
    .DEPTH (OUT_DIM),
    .IDX_W (BC_W),
    .DW    (PIX_W),
    .SUM_W (SUM_W)
  ) u_bank (
    .pxlclk (pxlclk),
    .rst_n  (rst_n),
    .wrEn   (winPix),
    .load   (accLoad),
    .idx    (bc),
    .addVal (inBus.DATA),
    .sumOut (sumOut)
  );

  // Block sum divided by BLK*BLK is a plain right shift.
  assign avg = PIX_W'(sumOut >> SHIFT);

`ifdef IMG_INVERT_EN
  assign pixOut = PIX_MAX - avg;
`else
  assign pixOut = avg;
`endif

  // Frame-level sequencing: start on FVAL rise, finish after the last
  // block, flag frames that end early.
  always_comb begin
    stateNext = state;
    errNext   = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (rising) stateNext = ACCUM;
      end
      ACCUM: begin
        if (!inBus.FVAL) begin
          errNext   = 1'b1;
          stateNext = WAIT_FRAME;
        end else if (lastPix && (outCnt == OUT_LAST_V)) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (!inBus.FVAL) stateNext = WAIT_FRAME;
      end
      default: stateNext = WAIT_FRAME;
    endcase
  end

  // Raster coordinates and output count; all held at zero outside ACCUM.
  always_comb begin
    xCntNext   = xCnt;
    yCntNext   = yCnt;
    outCntNext = outCnt;
    if (pixVld) begin
      if (xCnt == X_LAST_V) begin
        xCntNext = '0;
        yCntNext = (yCnt == Y_LAST_V) ? '0 : yCnt + 1'b1;
      end else begin
        xCntNext = xCnt + 1'b1;
      end
    end
    if (lastPix) outCntNext = outCnt + 1'b1;
    if (stateNext != ACCUM) begin
      xCntNext   = '0;
      yCntNext   = '0;
      outCntNext = '0;
    end
  end

  // FSM state and counters.
  always_ff @(posedge pxlclk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT_FRAME;
      xCnt   <= '0;
      yCnt   <= '0;
      outCnt <= '0;
    end else begin
      state  <= stateNext;
      xCnt   <= xCntNext;
      yCnt   <= yCntNext;
      outCnt <= outCntNext;
    end
  end

  // FVAL history for edge detection; it doubles as the delayed oFVAL.
  always_ff @(posedge pxlclk or negedge rst_n) begin
    if (!rst_n) begin
      fvalBuf <= 1'b0;
      armed   <= 1'b0;
    end else begin
      fvalBuf <= inBus.FVAL;
      armed   <= armed | ~inBus.FVAL;
    end
  end

  // Output registers: strobe one cycle after a block completes, data held.
  always_ff @(posedge pxlclk or negedge rst_n) begin
    if (!rst_n) begin
      dvalReg    <= 1'b0;
      dataReg    <= '0;
      oFrame_err <= 1'b0;
    end else begin
      dvalReg    <= lastPix;
      oFrame_err <= errNext;
      if (lastPix) dataReg <= 16'(pixOut);
    end
  end

  assign outBus.FVAL = fvalBuf;
  assign outBus.DVAL = dvalReg;
  assign outBus.DATA = dataReg;

endmodule

// File: tb/tb_img_downscale_28.sv
// Bench for img_downscale_28 on a reduced geometry (60x58 frame, 2x2 blocks,
// 28x28 output). Expected pixels are queued as each block's last pixel is
// driven and matched against the output strobes.
`timescale 1ns/1ps
module tb_img_downscale_28;
  import img_proc_pkg::*;

  localparam int IN_W    = 60;
  localparam int IN_H    = 58;
  localparam int BLK     = 2;
  localparam int OUT_DIM = IMG_DIM;
  localparam int PW      = 12;
  localparam int SPAN    = BLK * OUT_DIM;
  localparam int XO      = (IN_W - SPAN) / 2;
  localparam int YO      = (IN_H - SPAN) / 2;
  localparam int NOUT    = IMG_PIX_CNT;

  logic pxlclk = 1'b0;
  logic rst_n  = 1'b0;
  logic oFrameErr;

  img_downscale_28_if #(.DW(PW)) inBus ();
  img_downscale_28_if #(.DW(16)) outBus ();

  img_downscale_28 #(
    .IN_W    (IN_W),
    .IN_H    (IN_H),
    .BLK     (BLK),
    .OUT_DIM (OUT_DIM),
    .PIX_W   (PW)
  ) dut (
    .pxlclk     (pxlclk),
    .rst_n      (rst_n),
    .inBus      (inBus),
    .outBus     (outBus),
    .oFrame_err (oFrameErr)
  );

  always #5 pxlclk = ~pxlclk;

  int cyc = 0;
  always @(posedge pxlclk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int expQ[$];
  int cycQ[$];
  int gotCnt    = 0;
  int errCnt    = 0;
  int expErrCyc = -1;
  int popVal, popCyc;
  logic prevDval = 1'b0, prevErr = 1'b0, lastInFval = 1'b0;
  bit fvalChkOk = 1'b0;

  task automatic checkVal(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pixVal(input int mode, input int x, input int y);
    int rx, ry;
    bit win;
    rx  = x - XO;
    ry  = y - YO;
    win = (rx >= 0) && (rx < SPAN) && (ry >= 0) && (ry < SPAN);
    case (mode)
      0: return 100;
      1: return win ? 0 : 4095;
      default: begin
        if (!win) return 4095;
        if ((ry / BLK == 3) && (rx / BLK == 5)) return ((ry % BLK) < BLK / 2) ? 0 : 4095;
        return (rx / BLK) * 10 + (ry / BLK);
      end
    endcase
  endfunction

  function automatic int expPix(input int mode, input int r, input int c);
    int avg;
    case (mode)
      0: avg = 100;
      1: avg = 0;
      default: avg = ((r == 3) && (c == 5)) ? 2047 : c * 10 + r;
    endcase
`ifdef IMG_INVERT_EN
    avg = 4095 - avg;
`endif
    return avg;
  endfunction

  task automatic tick();
    @(posedge pxlclk);
    #1;
  endtask

  task automatic drive(input logic f, input logic d, input int v);
    inBus.FVAL = f;
    inBus.DVAL = d;
    inBus.DATA = PW'(v);
  endtask

  // Output monitor: one line per mismatching transaction.
  always @(negedge pxlclk) begin
    if (!rst_n) begin
      fvalChkOk = 1'b0;
      prevDval  = 1'b0;
      prevErr   = 1'b0;
    end else begin
      if (fvalChkOk) checkVal("ofval_delay", int'(outBus.FVAL), int'(lastInFval));
      fvalChkOk = 1'b1;
      if (outBus.DVAL) begin
        checkVal("dval_back_to_back", int'(prevDval), 0);
        if (expQ.size() == 0) begin
          checkVal("unexpected_dval", int'(outBus.DVAL), 0);
        end else begin
          popVal = expQ.pop_front();
          popCyc = cycQ.pop_front();
          checkVal("odata", int'(outBus.DATA), popVal);
          checkVal("odval_latency", cyc, popCyc);
        end
        gotCnt++;
      end
      if (oFrameErr) begin
        checkVal("err_width", int'(prevErr), 0);
        checkVal("err_cycle", cyc, expErrCyc);
        errCnt++;
      end
      prevDval = outBus.DVAL;
      prevErr  = oFrameErr;
    end
    lastInFval = inBus.FVAL;
  end

  // One frame: cutKind 0 = full, 1 = FVAL drop after cutAt outputs,
  // 2 = reset pulse after cutAt outputs (rest of frame must be skipped).
  task automatic runFrame(input int mode, input int gap, input int cutKind, input int cutAt);
    int  pushed;
    bit  stop, skipping;
    int  rx, ry;
    pushed    = 0;
    stop      = 1'b0;
    skipping  = 1'b0;
    gotCnt    = 0;
    errCnt    = 0;
    expErrCyc = -1;
    repeat (6) begin
      tick();
      drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom));
    end
    for (int y = 0; y < IN_H && !stop; y++) begin
      for (int x = 0; x < IN_W && !stop; x++) begin
        tick();
        drive(1'b1, 1'b1, pixVal(mode, x, y));
        rx = x - XO;
        ry = y - YO;
        if (!skipping && rx >= 0 && rx < SPAN && ry >= 0 && ry < SPAN &&
            (rx % BLK == BLK - 1) && (ry % BLK == BLK - 1)) begin
          expQ.push_back(expPix(mode, ry / BLK, rx / BLK));
          cycQ.push_back(cyc + 1);
          pushed++;
          if (cutKind == 1 && pushed == cutAt) begin
            tick();
            drive(1'b0, 1'b0, 0);
            expErrCyc = cyc + 1;
            stop = 1'b1;
          end else if (cutKind == 2 && pushed == cutAt) begin
            tick();
            drive(1'b1, 1'b0, 0);
            rst_n = 1'b0;
            expQ.delete();
            cycQ.delete();
            #1;
            checkVal("rst_mid_dval", int'(outBus.DVAL), 0);
            checkVal("rst_mid_data", int'(outBus.DATA), 0);
            checkVal("rst_mid_fval", int'(outBus.FVAL), 0);
            checkVal("rst_mid_err", int'(oFrameErr), 0);
            repeat (3) tick();
            rst_n    = 1'b1;
            skipping = 1'b1;
          end
        end
        if (!stop) begin
          for (int g = 0; g < gap; g++) begin
            tick();
            drive(1'b1, 1'b0, int'($urandom));
          end
        end
      end
    end
    tick();
    drive(1'b0, 1'b0, 0);
    repeat (8) begin
      tick();
      drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom));
    end
    checkVal("frame_pulses", gotCnt,
             (cutKind == 0) ? NOUT : ((cutKind == 1) ? cutAt : cutAt - 1));
    checkVal("frame_err_pulses", errCnt, (cutKind == 1) ? 1 : 0);
    checkVal("queue_drained", expQ.size(), 0);
    $display("frame mode=%0d gap=%0d cut=%0d: outputs=%0d err_pulses=%0d", mode, gap, cutKind, gotCnt, errCnt);
  endtask

  initial begin
    drive(1'b0, 1'b0, 0);
    rst_n = 1'b0;
    repeat (4) tick();
    checkVal("reset_dval", int'(outBus.DVAL), 0);
    checkVal("reset_data", int'(outBus.DATA), 0);
    checkVal("reset_fval", int'(outBus.FVAL), 0);
    checkVal("reset_err", int'(oFrameErr), 0);
    rst_n = 1'b1;

    runFrame(0, 0, 0, 0);    // constant 100
    runFrame(1, 0, 0, 0);    // crop window: outside 4095, inside 0
    runFrame(2, 0, 0, 0);    // block pattern with split block
    runFrame(0, 0, 1, 300);  // early FVAL drop
    runFrame(2, 0, 0, 0);    // full frame after abort
    runFrame(0, 0, 2, 500);  // reset mid-frame, remainder skipped
    runFrame(0, 0, 0, 0);    // full frame after reset
    runFrame(0, 2, 0, 0);    // one valid pixel per three cycles

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
